// File: rtl/tick_scheduler.sv
// Prescaled base tick plus NCH programmable periodic tick channels.
// Channel periods are loaded through a RUN/APPLY valid-ready handshake.
module tick_scheduler #(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned NCH      = 4,
    parameter int unsigned PW       = 16,
    localparam int unsigned CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned PSW     = $clog2(PRESCALE)
) (
    input  logic          I_CLK,
    input  logic          rst,
    input  logic          pause,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [PW-1:0] cfg_period,
    output logic          base_tick,
    output logic [NCH-1:0] tick
);

    localparam logic [PSW-1:0] PrescMax = PSW'(PRESCALE - 1);

    typedef enum logic {StRun, StApply} state_e;

    state_e state_q, state_d;

    logic [PSW-1:0] presc_q, presc_d;
    logic           base_q, base_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [PW-1:0]  period_q [NCH];
    logic [PW-1:0]  period_d [NCH];
    logic [PW-1:0]  cnt_q [NCH];
    logic [PW-1:0]  cnt_d [NCH];
    logic           accept;

    // FSM: state register
    always_ff @(posedge I_CLK) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state; APPLY always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:   if (cfg_valid) state_d = StApply;
            StApply: state_d = StRun;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cfg_ready = (state_q == StRun);
    end

    assign accept = cfg_valid && (state_q == StRun);

    always_comb begin
        presc_d = presc_q;
        base_d  = 1'b0;
        tick_d  = '0;
        if (!pause) begin
            if (presc_q == PrescMax) begin
                presc_d = '0;
                base_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        // Out-of-range cfg_ch matches no channel, so it is dropped here.
        for (int i = 0; i < NCH; i++) begin
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            if (accept && (int'(cfg_ch) == i)) begin
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
            end else if (period_q[i] == '0) begin
                cnt_d[i] = '0;
            end else if (base_q && !pause) begin
                if (cnt_q[i] == period_q[i] - 1'b1) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (rst) begin
            presc_q <= '0;
            base_q  <= 1'b0;
            tick_q  <= '0;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            presc_q <= presc_d;
            base_q  <= base_d;
            tick_q  <= tick_d;
            for (int i = 0; i < NCH; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign base_tick = base_q;
    assign tick      = tick_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: vector table for cadence/handshake/collision,
// hand sequences for pause, disable, reset-in-APPLY and out-of-range channel.
module tb_tick_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pause = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_period = '0;
    logic        base_tick;
    logic [3:0]  tick;

    logic        o_rst = 1'b1;
    logic        o_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  o_ch = '0;
    logic [15:0] o_per = '0;
    logic        o_base;
    logic [4:0]  o_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_scheduler #(.PRESCALE(4), .NCH(4), .PW(16)) u_dut (
        .I_CLK      (clk),
        .rst        (rst),
        .pause      (pause),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .base_tick  (base_tick),
        .tick       (tick)
    );

    // Five channels so that cfg_ch=5 is representable and out of range.
    tick_scheduler #(.PRESCALE(4), .NCH(5), .PW(16)) u_oor (
        .I_CLK      (clk),
        .rst        (o_rst),
        .pause      (1'b0),
        .cfg_valid  (o_valid),
        .cfg_ready  (o_ready),
        .cfg_ch     (o_ch),
        .cfg_period (o_per),
        .base_tick  (o_base),
        .tick       (o_tick)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [1:0]  ch;
        logic [15:0] per;
        logic        ready;
        logic        base;
        logic [3:0]  tick;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic v, input logic [1:0] c,
                                input logic [15:0] p, input logic er, input logic eb,
                                input logic [3:0] et);
        vec_t e;
        e.rst = r; e.valid = v; e.ch = c; e.per = p;
        e.ready = er; e.base = eb; e.tick = et;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic p, input logic v, input logic [1:0] c,
                         input logic [15:0] per);
        rst = r; pause = p; cfg_valid = v; cfg_ch = c; cfg_period = per;
        cyc();
    endtask

    task automatic expect3(input string tag, input logic er, input logic eb,
                           input logic [3:0] et);
        chk({tag, " ready"}, 32'(cfg_ready), 32'(er));
        chk({tag, " base"}, 32'(base_tick), 32'(eb));
        chk({tag, " tick"}, 32'(tick), 32'(et));
    endtask

    initial begin
        // reset, handshake (valid held 3 cycles), cadence, collision on ch1
        add(1, 0, 0, 0, 1, 0, 4'h0);   // v0
        add(0, 1, 0, 1, 0, 0, 4'h0);   // v1 ch0 p=1 accepted
        add(0, 1, 1, 3, 1, 0, 4'h0);   // v2 ignored in APPLY
        add(0, 1, 1, 3, 0, 0, 4'h0);   // v3 ch1 p=3 accepted
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v4
        add(0, 0, 0, 0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v8
        add(0, 0, 0, 0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v12
        add(0, 0, 0, 0, 1, 0, 4'h3);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v16
        add(0, 0, 0, 0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v20
        add(0, 0, 0, 0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v24
        add(0, 1, 1, 2, 0, 0, 4'h1);   // v25 reprogram ch1 as it would tick
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v28
        add(0, 0, 0, 0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 0, 1, 1, 4'h0);   // v32
        add(0, 0, 0, 0, 1, 0, 4'h3);   // v33

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, 1'b0, tbl[i].valid, tbl[i].ch, tbl[i].per);
            expect3($sformatf("vec%0d", i), tbl[i].ready, tbl[i].base, tbl[i].tick);
        end

        // pause for 10 cycles with prescaler at 2; cadence shifts by exactly 10
        drive(0, 0, 0, 0, 0);
        expect3("pre_pause", 1, 0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 0, 0, 0);
            expect3($sformatf("pause%0d", k), 1, 0, 4'h0);
        end
        for (int k = 1; k <= 7; k++) begin
            drive(0, 0, 0, 0, 0);
            expect3($sformatf("resume%0d", k), 1, (k == 2 || k == 6),
                    (k == 3) ? 4'h1 : (k == 7) ? 4'h3 : 4'h0);
        end

        // disable ch1 with period 0
        drive(0, 0, 1, 1, 0);
        expect3("disable_cfg", 0, 0, 4'h0);
        for (int k = 1; k <= 14; k++) begin
            drive(0, 0, 0, 0, 0);
            expect3($sformatf("disabled%0d", k), 1, (k % 4 == 2),
                    (k % 4 == 3) ? 4'h1 : 4'h0);
        end

        // cfg on ch0 at its tick edge (suppressed), then reset during APPLY
        drive(0, 0, 1, 0, 1);
        expect3("apply_before_rst", 0, 0, 4'h0);
        drive(1, 0, 1, 0, 1);
        expect3("rst_in_apply", 1, 0, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            drive(0, 0, 0, 0, 0);
            expect3($sformatf("post_rst%0d", k), 1, (k % 4 == 0), 4'h0);
        end

        // out-of-range channel on the 5-channel instance
        rst = 1'b1;
        o_rst = 1'b1;
        cyc();
        o_rst = 1'b0; o_valid = 1'b1; o_ch = 3'd0; o_per = 16'd2;
        cyc();
        chk("oor cfg0 ready", 32'(o_ready), 32'd0);
        o_valid = 1'b0;
        cyc();
        chk("oor apply done ready", 32'(o_ready), 32'd1);
        o_valid = 1'b1; o_ch = 3'd5; o_per = 16'd1;
        cyc();
        chk("oor ch5 ready", 32'(o_ready), 32'd0);
        o_valid = 1'b0;
        cyc();
        chk("oor ch5 done ready", 32'(o_ready), 32'd1);
        chk("oor base", 32'(o_base), 32'd1);
        for (int k = 5; k <= 17; k++) begin
            cyc();
            chk($sformatf("oor tick c%0d", k), 32'(o_tick),
                (k == 9 || k == 17) ? 32'd1 : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000, system clocks per base tick (1 ms at 100 MHz); legal range 2..2^24.
REQ-002 SHALL have parameter NCH, default 4, number of tick channels; legal range 1..8.
REQ-003 SHALL have parameter PW, default 16, channel period width in bits.
REQ-004 SHALL have port I_CLK  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port pause  in  1  freezes all counting while high.
REQ-007 SHALL have port cfg_valid  in  1  configuration request.
REQ-008 SHALL have port cfg_ready  out  1  configuration slot available.
REQ-009 SHALL have port cfg_ch  in  clog2(NCH) (min 1)  target channel.
REQ-010 SHALL have port cfg_period  in  PW  period in base ticks; 0 disables the channel.
REQ-011 SHALL have port base_tick  out  1  one-cycle pulse per prescaler wrap.
REQ-012 SHALL have port tick  out  NCH  per-channel one-cycle enable pulses.

Function
REQ-013 SHALL register all outputs; no combinational path from input to output.
REQ-014 SHALL count the prescaler 0..PRESCALE-1 while pause=0, wrapping to 0 after PRESCALE-1.
REQ-015 SHALL assert base_tick for exactly the one cycle following the edge at which the prescaler wraps.
REQ-016 SHALL hold prescaler and channel counters, and drive base_tick=0 and tick=0, in every cycle in which pause was high at the preceding edge.
REQ-017 SHALL keep, per channel, a PW-bit period register and a PW-bit counter.
REQ-018 SHALL, at each edge where base_tick=1 and period[i]!=0, wrap counter[i] to 0 if counter[i]==period[i]-1 and assert tick[i] for the following cycle; otherwise counter[i] increments and tick[i]=0.
REQ-019 SHALL therefore place tick[i] one cycle after the base_tick cycle that completes its period; period=1 ticks on every base tick.
REQ-020 SHALL hold counter[i] at 0 and tick[i] at 0 while period[i]==0.
REQ-021 SHALL implement a two-state FSM: RUN (cfg_ready=1) and APPLY (cfg_ready=0).
REQ-022 SHALL, in RUN, accept a configuration at an edge where cfg_valid=1 and cfg_ready=1: period[cfg_ch] <= cfg_period, counter[cfg_ch] <= 0; FSM -> APPLY.
REQ-023 SHALL leave APPLY for RUN after exactly one cycle, unconditionally; cfg_valid is ignored in APPLY.
REQ-024 SHALL ignore a configuration with cfg_ch >= NCH, but still complete the RUN -> APPLY -> RUN handshake.
REQ-025 SHALL give configuration priority over counting: at an accepting edge, the target channel takes the new period, its counter clears, and tick[cfg_ch] is 0 in the next cycle, even if it would have ticked; other channels count normally.
REQ-026 SHALL accept configuration while pause=1; the new period takes effect when counting resumes.
REQ-027 SHALL leave the prescaler phase unaffected by configuration.

Reset
REQ-028 SHALL, at an edge with rst=1, clear the prescaler, all counters and all periods to 0; base_tick=0, tick=0; FSM=RUN.
REQ-029 SHALL give rst priority over pause and cfg_valid; a mid-handshake APPLY is abandoned and cfg_ready=1 in the first cycle after reset.

Verification (PRESCALE=4, NCH=4, PW=16)
REQ-030 SHALL cover basic cadence: reset, cfg ch0 period=1, ch1 period=3 -> base_tick every 4 cycles; tick[0] one cycle after each base_tick; tick[1] after every 3rd base_tick; no other tick bits.
REQ-031 SHALL cover the handshake: cfg_valid held high for 3 cycles -> cfg_ready pattern 1,0,1; two configurations accepted, 2 cycles apart.
REQ-032 SHALL cover config/tick collision: reprogram ch1 to period=2 on the edge where it would complete -> no tick[1] that cycle; next tick[1] after 2 further base_ticks.
REQ-033 SHALL cover pause: pause high for 10 cycles mid-period -> base_tick and tick stay 0 throughout; cadence resumes with prescaler and counter values unchanged.
REQ-034 SHALL cover disable and out-of-range channel: period=0 on ch1 -> tick[1] never asserts; cfg_ch=5 -> no register change, cfg_ready still drops for one cycle.
REQ-035 SHALL cover mid-operation reset: rst during APPLY -> all outputs 0 next cycle, cfg_ready=1, no ticks until channels are reprogrammed.
